// File: rtl/hamming_secded_enc_pipe.sv
// Pipelined extended-Hamming (SECDED) encoder with a 2-entry skid buffer on a valid/ready stream.
// Optional error injection port when HAMMING_ENC_ERR_INJ_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------
// ST_EMPTY | R and S empty, nothing presented
// ST_ONE   | R holds the presented word
// ST_TWO   | R presented, S holds the next word; input stalled
`timescale 1ns/1ps
module hamming_secded_enc_pipe #(
  parameter int DATA_W = 4,
  parameter int SB_W   = 1,
  parameter int CNT_W  = 16,
  localparam int P = (DATA_W <= 1)  ? 2 :
                     (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 : 7,
  localparam int HAM_W  = DATA_W + P,
  localparam int CODE_W = HAM_W + 1,
  localparam int SBW_I  = (SB_W > 0) ? SB_W : 1,
  localparam int OUT_W  = CODE_W + SB_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SBW_I-1:0]  i_sb,
`ifdef HAMMING_ENC_ERR_INJ_EN
  input  logic [CODE_W-1:0] i_err_mask,
`endif
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_code,
  output logic [CNT_W-1:0]  o_word_cnt
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   r_q, r_d;
  logic [OUT_W-1:0]   s_q, s_d;
  logic               ready_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [HAM_W-1:0]   data_placed;
  logic [HAM_W-1:0]   ham;
  logic [CODE_W-1:0]  enc_code;
  logic [OUT_W-1:0]   enc_word;
  logic               in_xfer;
  logic               out_xfer;

  // Scatter payload into non-power-of-two positions, then fill parity slots from that.
  always_comb begin
    int di;
    logic acc;
    data_placed = '0;
    di = 0;
    for (int pos = 1; pos <= HAM_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        data_placed[pos-1] = i_data[di];
        di++;
      end
    end
    ham = data_placed;
    for (int j = 0; j < P; j++) begin
      acc = 1'b0;
      for (int pos = 1; pos <= HAM_W; pos++) begin
        if (((pos >> j) & 1) == 1) acc = acc ^ data_placed[pos-1];
      end
      ham[(1 << j) - 1] = acc;
    end
    enc_code = {^ham, ham};
`ifdef HAMMING_ENC_ERR_INJ_EN
    enc_code = enc_code ^ i_err_mask;
`endif
  end

  generate
    if (SB_W > 0) begin : g_sb
      assign enc_word = {i_sb, enc_code};
    end else begin : g_no_sb
      logic unused_sb;
      assign unused_sb = ^i_sb;
      assign enc_word  = enc_code;
    end
  endgenerate

  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = (state_q != ST_EMPTY) && i_ready;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          r_d     = enc_word;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          r_d = enc_word;
        end else if (in_xfer) begin
          s_d     = enc_word;
          state_d = ST_TWO;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          r_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      r_q     <= '0;
      s_q     <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      ready_q <= (state_d != ST_TWO);
      if (out_xfer) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = (state_q != ST_EMPTY);
  assign o_code     = r_q;
  assign o_word_cnt = cnt_q;

endmodule
